// File: rtl/mem_source_if.sv
// Bundle of control, memory-read and FIFO-write signals for the sample feeder.
// Latency: none (wires only).
// Backpressure: carries Full_i from the FIFO back to the feeder.
interface mem_source_if #(
  parameter int ADDR_WIDTH = $clog2(100),
  parameter int DATA_WIDTH = 32
) ();
  logic                  start_i;
  logic [ADDR_WIDTH-1:0] ilen;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  Read_Enable_o;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  Full_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  Write_Enable_o;
  logic                  busy;
  logic                  done;

  // Feeder side.
  modport master (
    input  start_i, ilen, data_i, Full_i,
    output addr, Read_Enable_o, data_o, Write_Enable_o, busy, done
  );

  // Environment side (memory, FIFO and controller).
  modport slave (
    output start_i, ilen, data_i, Full_i,
    input  addr, Read_Enable_o, data_o, Write_Enable_o, busy, done
  );
endinterface

// File: rtl/mem_source.sv
// Streams samples 0..ilen-1 from a sync-read memory into the core's input FIFO.
// Latency: first FIFO write 3 cycles after start, then one sample per cycle.
// Backpressure: Full_i stalls writes; out+skid hold 2 samples, reads throttle at occ=2.
module mem_source #(
  parameter int ADDR_WIDTH = $clog2(100),
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_source_if.master  bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic [ADDR_WIDTH-1:0] wr_cnt;
  logic                  out_valid;
  logic                  skid_valid;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] out_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic [1:0]            occ;
  logic                  fetch;
  logic                  xfer;
  logic                  rd_en;

  assign fetch = (state == FETCH);
  assign xfer  = out_valid & ~bus.Full_i;
  // Samples owned by this stage: buffered ones plus the read still returning.
  assign occ   = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, inflight};
  // A read is allowed only if its data will have a register to land in.
  assign rd_en = fetch & (rd_cnt < len_q) & ((occ < 2'd2) | xfer);

  assign bus.addr           = rd_cnt;
  assign bus.Read_Enable_o  = rd_en;
  assign bus.Write_Enable_o = xfer;
  assign bus.data_o         = out_q;
  assign bus.busy           = fetch;
  assign bus.done           = (state == DONE);

  // Sequencing and address/write counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      len_q  <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            len_q  <= bus.ilen;
            rd_cnt <= '0;
            wr_cnt <= '0;
            state  <= (bus.ilen == '0) ? DONE : FETCH;
          end
        end
        FETCH: begin
          if (rd_en) rd_cnt <= rd_cnt + ONE;
          if (xfer) begin
            wr_cnt <= wr_cnt + ONE;
            // Leave on the last write so done lands the very next cycle.
            if (wr_cnt == len_q - ONE) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Two-deep output buffer: out register feeds the FIFO, skid absorbs a stalled return.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight   <= 1'b0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      inflight <= rd_en;

      if (xfer && skid_valid) begin
        out_q     <= skid_q;
        out_valid <= 1'b1;
      end else if (inflight && (!out_valid || xfer)) begin
        out_q     <= bus.data_i;
        out_valid <= 1'b1;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end

      if (inflight && out_valid && !(xfer && !skid_valid)) begin
        skid_q     <= bus.data_i;
        skid_valid <= 1'b1;
      end else if (xfer && skid_valid) begin
        skid_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/mem_source.md
# mem_source

Upstream feeder for the interpolator chain. On `start_i` it reads `ilen` samples from a synchronous-read sample memory at addresses 0..ilen-1 and pushes them in order into the input FIFO of the processing core. It observes FIFO backpressure through `Full_i` and never loses or duplicates a sample. It is the mirror of the output sink stage, which drains the core's output FIFO back into memory.

## Interface
Parameters:
- `ADDR_WIDTH`, default $clog2(100) (=7): width of the memory address and of the length field.
- `DATA_WIDTH`, default 32: sample width.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start_i`, input, 1: start request. Sampled only in IDLE.
- `ilen`, input, ADDR_WIDTH: number of samples to transfer. Latched at start.
- `addr`, output, ADDR_WIDTH: memory read address.
- `Read_Enable_o`, output, 1: memory read strobe.
- `data_i`, input, DATA_WIDTH: memory read data, valid the cycle after `Read_Enable_o`.
- `Full_i`, input, 1: downstream FIFO full.
- `data_o`, output, DATA_WIDTH: sample to the FIFO.
- `Write_Enable_o`, output, 1: FIFO write strobe.
- `busy`, output, 1: high in FETCH.
- `done`, output, 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE → FETCH → DONE → IDLE.
  - IDLE: when `start_i`=1, latch `ilen` into len_q, clear rd_cnt and wr_cnt, and go to FETCH. If the latched `ilen`=0, go straight to DONE instead.
  - FETCH: issue reads and writes as below. When wr_cnt reaches len_q, go to DONE.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- `start_i` is ignored outside IDLE. `ilen` changes after start have no effect.
- Read issue: `addr` = rd_cnt.
  - `Read_Enable_o` = FETCH & (rd_cnt < len_q) & (occ < 2 | xfer).
  - occ = out_valid + skid_valid + inflight. Its range is 0..2.
  - inflight is the registered `Read_Enable_o`.
  - rd_cnt increments on every read.
- Transfer: xfer = `Write_Enable_o` = out_valid & ~`Full_i`. This is combinational, so a write is never presented while the FIFO is full. `data_o` = out register. wr_cnt increments on xfer.
- Data capture, when inflight=1:
  - If out_valid=0, or xfer with skid empty: `data_i` goes to the out register.
  - Otherwise: `data_i` goes to the skid register.
- Skid drain: on xfer with skid_valid=1, the skid register moves to the out register and skid_valid clears, unless new data refills it in the same cycle.
- Ordering is strictly ascending address. Every address in 0..len_q-1 is written exactly once.
- Width rules:
  - rd_cnt and wr_cnt are ADDR_WIDTH bits. Because len_q ≤ 2^ADDR_WIDTH-1, they never wrap.
  - Comparisons are unsigned.

## Timing
- Reset values:
  - state=IDLE.
  - `addr`=0, `Read_Enable_o`=0, `Write_Enable_o`=0, `data_o`=0, `busy`=0, `done`=0.
  - out_valid=0, skid_valid=0, inflight=0, rd_cnt=0, wr_cnt=0.
- Reset mid-operation: returns to IDLE on the next edge. Reads in flight are discarded. No write occurs from the cycle after reset is asserted.
- Latency, with `start_i` high in cycle 0:
  - FETCH from cycle 1. First `Read_Enable_o` in cycle 1 at `addr`=0.
  - `data_i` valid in cycle 2. First `Write_Enable_o` in cycle 3 if `Full_i`=0.
- Throughput: with `Full_i` held low, one sample per cycle. Writes occur in cycles 3..N+2, `done` in cycle N+3, IDLE in cycle N+4.
- Backpressure:
  - While `Full_i`=1, `Write_Enable_o`=0 and `data_o` holds.
  - At most two samples are buffered (out + skid). Reads stop once occ=2 with no xfer.
  - When `Full_i` deasserts, writes resume the same cycle.
- Simultaneous events:
  - A read return and an xfer in the same cycle is lossless.
  - `Full_i` toggling every cycle yields writes only in its low cycles.
- `done` and `busy` are never high in the same cycle.

## Test plan
- `ilen`=5, memory[i]=0xA0+i, `Full_i`=0 → `Read_Enable_o` in cycles 1–5 (addr 0–4); writes 0xA0..0xA4 in cycles 3–7; `done` pulse in cycle 8.
- `ilen`=0 → no `Read_Enable_o`, no write, `done` high in cycle 1 only.
- `ilen`=8, `Full_i` held high during cycles 4–9 → exactly 2 samples buffered; writes resume in cycle 10; output sequence is 0..7 with no gaps or duplicates.
- `ilen`=6, `Full_i` alternating 1/0 each cycle → 6 writes, each in a `Full_i`=0 cycle, in address order; single `done` pulse.
- `rst` asserted in cycle 4 of an `ilen`=10 run → all outputs 0 from cycle 5; a fresh start with `ilen`=3 then delivers addresses 0–2.
- `start_i` pulsed again, and `ilen` changed to 2, during a FETCH with `ilen`=4 → ignored; exactly 4 writes and one `done`.
